dma_mem_target: RTL and testbench

- Memory-side responder for the DMA control-bus handshake. The DMA channel, as bus master, raises IReady with MEMWR and an address; this block completes the transfer against an internal RAM and answers with TReady.
- Sits on the system control bus opposite the DMA timing/control logic. Also serves as the bus-functional memory model in DMA integration benches.
- Tri-state bus drivers live at top level; this block exposes separate value and output-enable pins.

---
 rtl/dma_bus_pkg.sv | 21 ++
 rtl/dma_mem_target_if.sv | 26 ++
 rtl/dma_mem_array.sv | 27 ++
 rtl/dma_mem_target.sv | 137 +++++++++++++
 tb/tb_dma_mem_target.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dma_bus_pkg.sv
// Shared types and constants for the DMA control-bus memory target.
// Covers the FSM state encoding, transfer-count width and memwr encoding.
package dma_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        ACK     = 2'd2,
        RELEASE = 2'd3
    } dma_state_e;

    localparam int   XFER_CNT_W = 16;
    localparam logic MEM_WRITE  = 1'b1;
    localparam logic MEM_READ   = 1'b0;

    // Word-index width for a RAM of the given depth (at least one bit).
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/dma_mem_target_if.sv
// DMA control-bus signals between the DMA channel (master) and a memory target (slave).
// Tri-state drivers live at top level, so each driven bus signal has a separate enable.
interface dma_mem_target_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              aen;
    logic [ADDR_W-1:0] addr;
    logic              iready;
    logic              memwr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              tready;
    logic              tready_oe;

    modport master (
        output aen, addr, iready, memwr, data_in,
        input  data_out, data_oe, tready, tready_oe
    );

    modport slave (
        input  aen, addr, iready, memwr, data_in,
        output data_out, data_oe, tready, tready_oe
    );
endinterface

// File: rtl/dma_mem_array.sv
// Synchronous-write, asynchronous-read RAM backing the DMA memory target.
// The target samples rdata on the edge it acknowledges a read.
module dma_mem_array
    import dma_bus_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dma_mem_target.sv
// Memory-side responder for the DMA four-phase IReady/TReady handshake.
// Captures a request, inserts WAIT_STATES cycles, then completes it against an internal RAM.
module dma_mem_target
    import dma_bus_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    dma_mem_target_if.slave       bus,
    output logic                  addr_err,
    output logic [XFER_CNT_W-1:0] xfer_cnt
);

    localparam int              IDX_W   = idx_width(DEPTH);
    localparam int              WS_M1   = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]      WS_LOAD = WS_M1[3:0];
    localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];

    dma_state_e            state;
    logic [3:0]            wcnt;
    logic                  tready_q;
    logic                  data_oe_q;
    logic [DATA_W-1:0]     data_out_q;
    logic                  addr_err_q;
    logic [XFER_CNT_W-1:0] xfer_cnt_q;

    logic [ADDR_W-1:0]     addr_p0;
    logic                  memwr_p0;
    logic [DATA_W-1:0]     wdata_p0;

    logic                  accept;
    logic                  in_range;
    logic                  commit;
    logic                  mem_we;
    logic [DATA_W-1:0]     rdata;

    assign accept   = (state == IDLE) && bus.aen && bus.iready;
    assign in_range = ({1'b0, addr_p0} < DEPTH_L);

    // The first ACK cycle (tready still low) is the completion edge.
    assign commit   = (state == ACK) && !tready_q && bus.aen && bus.iready;
    assign mem_we   = commit && (memwr_p0 == MEM_WRITE) && in_range;

    // Stage 0: request capture; later bus changes are ignored until the next accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_p0  <= bus.addr;
            memwr_p0 <= bus.memwr;
            wdata_p0 <= bus.data_in;
        end
    end

    dma_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (addr_p0[IDX_W-1:0]),
        .wdata (wdata_p0),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wcnt       <= '0;
            tready_q   <= 1'b0;
            data_oe_q  <= 1'b0;
            data_out_q <= '0;
            addr_err_q <= 1'b0;
            xfer_cnt_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        wcnt  <= WS_LOAD;
                        state <= (WAIT_STATES > 0) ? WAIT : ACK;
                    end
                end
                WAIT: begin
                    if (!(bus.aen && bus.iready)) begin
                        state <= IDLE;
                    end else if (wcnt == 4'd0) begin
                        state <= ACK;
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                ACK: begin
                    if (!bus.aen) begin
                        state     <= IDLE;
                        tready_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                    end else if (!tready_q) begin
                        if (!bus.iready) begin
                            state <= IDLE;
                        end else begin
                            tready_q   <= 1'b1;
                            xfer_cnt_q <= xfer_cnt_q + 1'b1;
                            if (!in_range) begin
                                addr_err_q <= 1'b1;
                            end
                            if (memwr_p0 == MEM_READ) begin
                                data_out_q <= in_range ? rdata : '0;
                                data_oe_q  <= 1'b1;
                            end
                        end
                    end else if (!bus.iready) begin
                        state     <= RELEASE;
                        tready_q  <= 1'b0;
                        data_oe_q <= 1'b0;
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.tready    = tready_q;
    assign bus.tready_oe = (state != IDLE);
    assign bus.data_oe   = data_oe_q;
    assign bus.data_out  = data_out_q;
    assign addr_err      = addr_err_q;
    assign xfer_cnt      = xfer_cnt_q;

endmodule

// File: tb/tb_dma_mem_target.sv
// Directed bench for dma_mem_target: three configurations (WAIT_STATES 0/1/3, DEPTH 256/128)
// exercised by a transfer table plus hand-written multi-cycle sequences.
module tb_dma_mem_target;
    import dma_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Index 0: WAIT_STATES=0 DEPTH=256; 1: WAIT_STATES=1 DEPTH=128; 2: WAIT_STATES=3 DEPTH=256.
    logic        aen_v    [3];
    logic        iready_v [3];
    logic        memwr_v  [3];
    logic [7:0]  addr_v   [3];
    logic [7:0]  din_v    [3];
    logic [7:0]  dout_w   [3];
    logic        doe_w    [3];
    logic        trdy_w   [3];
    logic        toe_w    [3];
    logic        err_w    [3];
    logic [15:0] cnt_w    [3];

    dma_mem_target_if #(.ADDR_W(8), .DATA_W(8)) b0 ();
    dma_mem_target_if #(.ADDR_W(8), .DATA_W(8)) b1 ();
    dma_mem_target_if #(.ADDR_W(8), .DATA_W(8)) b3 ();

    assign b0.aen = aen_v[0];  assign b0.iready = iready_v[0];  assign b0.memwr = memwr_v[0];
    assign b0.addr = addr_v[0]; assign b0.data_in = din_v[0];
    assign b1.aen = aen_v[1];  assign b1.iready = iready_v[1];  assign b1.memwr = memwr_v[1];
    assign b1.addr = addr_v[1]; assign b1.data_in = din_v[1];
    assign b3.aen = aen_v[2];  assign b3.iready = iready_v[2];  assign b3.memwr = memwr_v[2];
    assign b3.addr = addr_v[2]; assign b3.data_in = din_v[2];

    assign dout_w[0] = b0.data_out; assign doe_w[0] = b0.data_oe;
    assign trdy_w[0] = b0.tready;   assign toe_w[0] = b0.tready_oe;
    assign dout_w[1] = b1.data_out; assign doe_w[1] = b1.data_oe;
    assign trdy_w[1] = b1.tready;   assign toe_w[1] = b1.tready_oe;
    assign dout_w[2] = b3.data_out; assign doe_w[2] = b3.data_oe;
    assign trdy_w[2] = b3.tready;   assign toe_w[2] = b3.tready_oe;

    dma_mem_target #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(0)) u0 (
        .clk(clk), .reset(reset), .bus(b0), .addr_err(err_w[0]), .xfer_cnt(cnt_w[0]));
    dma_mem_target #(.ADDR_W(8), .DATA_W(8), .DEPTH(128), .WAIT_STATES(1)) u1 (
        .clk(clk), .reset(reset), .bus(b1), .addr_err(err_w[1]), .xfer_cnt(cnt_w[1]));
    dma_mem_target #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT_STATES(3)) u3 (
        .clk(clk), .reset(reset), .bus(b3), .addr_err(err_w[2]), .xfer_cnt(cnt_w[2]));

    typedef struct {
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  din;
        logic [7:0]  exp_rd;
        logic        exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] rd;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Full four-phase transfer from IDLE; request fields are scrambled right after capture.
    task automatic xfer(input int i, input logic wr, input logic [7:0] a, input logic [7:0] d,
                        input int exp_lat, output logic [7:0] rdata);
        int lat;
        bit seen;
        @(negedge clk);
        aen_v[i] = 1'b1; memwr_v[i] = wr; addr_v[i] = a; din_v[i] = d; iready_v[i] = 1'b1;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            cyc();
            lat++;
            if (lat == 1) begin
                memwr_v[i] = ~wr; addr_v[i] = a ^ 8'hFF; din_v[i] = ~d;
            end
            if (trdy_w[i]) seen = 1'b1;
        end
        chk($sformatf("latency[%0d]", i), lat, exp_lat);
        rdata = dout_w[i];
        if (!wr) chk($sformatf("data_oe_ack[%0d]", i), 32'(doe_w[i]), 1);
        iready_v[i] = 1'b0;
        cyc();
        chk($sformatf("release_tready[%0d]", i), 32'(trdy_w[i]), 0);
        chk($sformatf("release_oe[%0d]", i), 32'(doe_w[i]), 0);
        chk($sformatf("release_toe[%0d]", i), 32'(toe_w[i]), 1);
        cyc();
        chk($sformatf("idle_toe[%0d]", i), 32'(toe_w[i]), 0);
        aen_v[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            aen_v[i] = 1'b0; iready_v[i] = 1'b0; memwr_v[i] = MEM_READ;
            addr_v[i] = 8'h00; din_v[i] = 8'h00;
        end

        tbl[0] = '{1'b1, 8'h12, 8'hA5, 8'h00, 1'b0, 16'd1};
        tbl[1] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b0, 16'd2};
        tbl[2] = '{1'b1, 8'h00, 8'h3C, 8'h00, 1'b0, 16'd3};
        tbl[3] = '{1'b1, 8'h7F, 8'hC3, 8'h00, 1'b0, 16'd4};
        tbl[4] = '{1'b0, 8'h7F, 8'h00, 8'hC3, 1'b0, 16'd5};
        tbl[5] = '{1'b1, 8'h80, 8'h55, 8'h00, 1'b1, 16'd6};
        tbl[6] = '{1'b0, 8'h00, 8'h00, 8'h3C, 1'b1, 16'd7};
        tbl[7] = '{1'b0, 8'h80, 8'h00, 8'h00, 1'b1, 16'd8};
        tbl[8] = '{1'b0, 8'h12, 8'h00, 8'hA5, 1'b1, 16'd9};

        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_tready[%0d]", i), 32'(trdy_w[i]), 0);
            chk($sformatf("rst_toe[%0d]", i), 32'(toe_w[i]), 0);
            chk($sformatf("rst_doe[%0d]", i), 32'(doe_w[i]), 0);
            chk($sformatf("rst_dout[%0d]", i), 32'(dout_w[i]), 0);
            chk($sformatf("rst_err[%0d]", i), 32'(err_w[i]), 0);
            chk($sformatf("rst_cnt[%0d]", i), 32'(cnt_w[i]), 0);
        end
        reset = 1'b0;

        // Transfer table on WAIT_STATES=1, DEPTH=128.
        for (int k = 0; k < 9; k++) begin
            xfer(1, tbl[k].wr, tbl[k].addr, tbl[k].din, 3, rd);
            if (!tbl[k].wr) chk($sformatf("tbl%0d_rdata", k), 32'(rd), 32'(tbl[k].exp_rd));
            chk($sformatf("tbl%0d_err", k), 32'(err_w[1]), 32'(tbl[k].exp_err));
            chk($sformatf("tbl%0d_cnt", k), 32'(cnt_w[1]), 32'(tbl[k].exp_cnt));
        end

        // WAIT_STATES=0: hold, RELEASE gap and back-to-back request.
        xfer(0, MEM_WRITE, 8'h40, 8'h5A, 2, rd);
        @(negedge clk);
        aen_v[0] = 1'b1; iready_v[0] = 1'b1; memwr_v[0] = MEM_READ; addr_v[0] = 8'h40;
        cyc();
        chk("ws0_captured_toe", 32'(toe_w[0]), 1);
        chk("ws0_captured_tready", 32'(trdy_w[0]), 0);
        cyc();
        chk("ws0_ack_tready", 32'(trdy_w[0]), 1);
        chk("ws0_ack_rdata", 32'(dout_w[0]), 32'h5A);
        repeat (2) cyc();
        chk("ws0_hold_tready", 32'(trdy_w[0]), 1);
        iready_v[0] = 1'b0;
        cyc();
        chk("ws0_release_tready", 32'(trdy_w[0]), 0);
        chk("ws0_release_doe", 32'(doe_w[0]), 0);
        iready_v[0] = 1'b1;
        cyc();
        chk("ws0_b2b_idle_toe", 32'(toe_w[0]), 0);
        cyc();
        chk("ws0_b2b_captured_toe", 32'(toe_w[0]), 1);
        chk("ws0_b2b_captured_tready", 32'(trdy_w[0]), 0);
        cyc();
        chk("ws0_b2b_tready", 32'(trdy_w[0]), 1);
        chk("ws0_b2b_rdata", 32'(dout_w[0]), 32'h5A);
        iready_v[0] = 1'b0;
        repeat (2) cyc();
        aen_v[0] = 1'b0;
        chk("ws0_cnt", 32'(cnt_w[0]), 3);

        // aen dropping in ACK: immediate deassert, committed write stays.
        aen_v[0] = 1'b1; iready_v[0] = 1'b1; memwr_v[0] = MEM_WRITE; addr_v[0] = 8'h41; din_v[0] = 8'h11;
        repeat (2) cyc();
        chk("aen_drop_pre_tready", 32'(trdy_w[0]), 1);
        aen_v[0] = 1'b0;
        cyc();
        chk("aen_drop_tready", 32'(trdy_w[0]), 0);
        chk("aen_drop_toe", 32'(toe_w[0]), 0);
        iready_v[0] = 1'b0;
        chk("aen_drop_cnt", 32'(cnt_w[0]), 4);
        xfer(0, MEM_READ, 8'h41, 8'h00, 2, rd);
        chk("aen_drop_write_kept", 32'(rd), 32'h11);
        chk("aen_drop_cnt2", 32'(cnt_w[0]), 5);

        // WAIT_STATES=3: abort in WAIT leaves RAM and count untouched.
        xfer(2, MEM_WRITE, 8'h20, 8'h77, 5, rd);
        @(negedge clk);
        aen_v[2] = 1'b1; iready_v[2] = 1'b1; memwr_v[2] = MEM_WRITE; addr_v[2] = 8'h20; din_v[2] = 8'h99;
        cyc();
        chk("abort_wait_toe", 32'(toe_w[2]), 1);
        iready_v[2] = 1'b0;
        cyc();
        chk("abort_idle_toe", 32'(toe_w[2]), 0);
        repeat (4) cyc();
        chk("abort_no_tready", 32'(trdy_w[2]), 0);
        aen_v[2] = 1'b0;
        chk("abort_cnt", 32'(cnt_w[2]), 1);
        xfer(2, MEM_READ, 8'h20, 8'h00, 5, rd);
        chk("abort_ram_unchanged", 32'(rd), 32'h77);
        chk("abort_cnt2", 32'(cnt_w[2]), 2);

        // Counter wrap.
        @(negedge clk);
        force u0.xfer_cnt_q = 16'hFFFF;
        #1;
        release u0.xfer_cnt_q;
        chk("wrap_preload", 32'(cnt_w[0]), 32'hFFFF);
        xfer(0, MEM_READ, 8'h40, 8'h00, 2, rd);
        chk("wrap_cnt", 32'(cnt_w[0]), 0);

        // Asynchronous reset while in ACK.
        @(negedge clk);
        aen_v[1] = 1'b1; iready_v[1] = 1'b1; memwr_v[1] = MEM_READ; addr_v[1] = 8'h12;
        repeat (3) cyc();
        chk("rst_ack_pre_tready", 32'(trdy_w[1]), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("rst_ack_tready", 32'(trdy_w[1]), 0);
        chk("rst_ack_doe", 32'(doe_w[1]), 0);
        chk("rst_ack_toe", 32'(toe_w[1]), 0);
        chk("rst_ack_err", 32'(err_w[1]), 0);
        chk("rst_ack_cnt", 32'(cnt_w[1]), 0);
        aen_v[1] = 1'b0; iready_v[1] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        xfer(1, MEM_READ, 8'h12, 8'h00, 3, rd);
        chk("post_rst_rdata", 32'(rd), 32'hA5);
        chk("post_rst_cnt", 32'(cnt_w[1]), 1);
        chk("post_rst_err", 32'(err_w[1]), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
